// File: rtl/imm_ext_pkg.sv
// Opcode encodings and buffer occupancy states shared by the immediate-extension pipe.
package imm_ext_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SHAMT  = 3'd0;
  localparam logic [OP_W-1:0] OP_ZERO   = 3'd1;
  localparam logic [OP_W-1:0] OP_SIGN   = 3'd2;
  localparam logic [OP_W-1:0] OP_UPPER  = 3'd3;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational opcode -> extended operand; zero latency, no handshake.
// Unknown opcodes yield zero data with err set.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SH_LO = 6,
  parameter int SH_W  = 5
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    case (op_i)
      OP_SHAMT:  data_o = {{(OUT_W-SH_W){1'b0}}, imm_i[SH_LO+SH_W-1:SH_LO]};
      OP_ZERO:   data_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
      OP_SIGN:   data_o = sext;
      OP_UPPER:  data_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
      // Word-scaled branch offset: top two sign bits fall off the end.
      OP_BRANCH: data_o = {sext[OUT_W-3:0], 2'b00};
      default:   err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry output buffer; beat accepted at edge N is visible after N.
// in_ready is registered (no path from out_ready); optional IMM_EXT_PERF_EN adds xfer/stall counters.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SH_LO = 6,
  parameter int SH_W  = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int E_W = OUT_W + TAG_W + 1;

  occ_e             state_q, state_d;
  logic             in_ready_q;
  logic [E_W-1:0]   hd_q, sp_q;
  logic [E_W-1:0]   new_ent;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SH_LO (SH_LO),
    .SH_W  (SH_W)
  ) u_core (
    .imm_i  (in_imm),
    .op_i   (in_op),
    .data_o (ext_data),
    .err_o  (ext_err)
  );

  // Entries are stored already extended so the output side is pure wiring.
  assign new_ent = {ext_err, in_tag, ext_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = in_ready_q;
    push      = in_valid && in_ready_q;
    pop       = out_valid && out_ready;
  end

  // Head register feeds the outputs directly; the spare holds the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_q <= '0;
      sp_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) hd_q <= new_ent;
        ST_ONE: begin
          if (push && pop) hd_q <= new_ent;
          else if (push)   sp_q <= new_ent;
        end
        ST_FULL:  if (pop) hd_q <= sp_q;
        default: ;
      endcase
    end
  end

  assign out_data = hd_q[OUT_W-1:0];
  assign out_tag  = hd_q[OUT_W+TAG_W-1:OUT_W];
  assign out_err  = hd_q[E_W-1];

`ifdef IMM_EXT_PERF_EN
  logic [31:0] xfer_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop && (xfer_q != 32'hFFFF_FFFF))
        xfer_q <= xfer_q + 32'd1;
      if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed + random bench for imm_ext_pipe against a queue-based reference model.
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int SH_LO = 6;
  localparam int SH_W  = 5;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
`ifdef IMM_EXT_PERF_EN
  logic [31:0]      xfer_cnt;
  logic [31:0]      stall_cnt;
`endif

  always #5 clk = ~clk;

  imm_ext_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SH_LO (SH_LO),
    .SH_W  (SH_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
`ifdef IMM_EXT_PERF_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [TAG_W-1:0] t;
    logic             e;
  } beat_t;

  beat_t  q[$];
  bit     rdy_exp;
  longint xfer_exp, stall_exp;
  int     n_cmp = 0;
  int     n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Extension rules computed with plain integer arithmetic modulo 2^OUT_W.
  function automatic beat_t model(input logic [2:0] op, input logic [IN_W-1:0] imm,
                                  input logic [TAG_W-1:0] tag);
    longint u = longint'(imm);
    longint s = imm[IN_W-1] ? u - (longint'(1) << IN_W) : u;
    longint m = longint'(1) << OUT_W;
    longint r;
    beat_t  b;
    b.t = tag;
    b.e = 1'b0;
    case (op)
      3'd0:    r = (u >> SH_LO) % (longint'(1) << SH_W);
      3'd1:    r = u;
      3'd2:    r = s;
      3'd3:    r = u * (longint'(1) << (OUT_W - IN_W));
      3'd4:    r = s * 4;
      default: begin r = 0; b.e = 1'b1; end
    endcase
    r   = ((r % m) + m) % m;
    b.d = r[OUT_W-1:0];
    return b;
  endfunction

  task automatic step(input bit v, input logic [2:0] op, input logic [IN_W-1:0] imm,
                      input logic [TAG_W-1:0] tag, input bit ordy, output bit acc);
    bit    pop;
    beat_t h;
    in_valid  = v;
    in_op     = v ? op  : 3'($urandom);
    in_imm    = v ? imm : IN_W'($urandom);
    in_tag    = v ? tag : TAG_W'($urandom);
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, rdy_exp);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      chk("out_data", out_data, h.d);
      chk("out_tag", out_tag, h.t);
      chk("out_err", out_err, h.e);
    end
`ifdef IMM_EXT_PERF_EN
    chk("xfer_cnt", xfer_cnt, xfer_exp);
    chk("stall_cnt", stall_cnt, stall_exp);
`endif
    acc = v && rdy_exp;
    pop = (q.size() > 0) && ordy;
    if (pop) xfer_exp++;
    if ((q.size() > 0) && !ordy) stall_exp++;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(model(op, imm, tag));
    rdy_exp = (q.size() < 2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_tag"}, out_tag, '0);
    chk({tag, "_out_err"}, out_err, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
`ifdef IMM_EXT_PERF_EN
    chk({tag, "_xfer_cnt"}, xfer_cnt, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_mid();
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    q.delete();
    rdy_exp   = 1'b0;
    xfer_exp  = 0;
    stall_exp = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_exp = 1'b1;
  endtask

  initial begin
    bit a;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    rdy_exp   = 1'b0;
    xfer_exp  = 0;
    stall_exp = 0;
    #3;
    chk_reset_outputs("por");
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_exp = 1'b1;

    // Each opcode once, streaming.
    step(1, 3'd2, 16'h8001, 4'd1, 1, a);
    step(1, 3'd1, 16'h8001, 4'd2, 1, a);
    step(1, 3'd0, 16'h07C0, 4'd3, 1, a);
    step(1, 3'd3, 16'h1234, 4'd4, 1, a);
    step(1, 3'd4, 16'hFFFF, 4'd5, 1, a);
    step(1, 3'd4, 16'h0004, 4'd6, 1, a);
    step(0, 3'd0, 16'h0000, 4'd0, 1, a);

    // Backpressure: third beat must wait until the buffer drains.
    step(1, 3'd1, 16'h0011, 4'd1, 0, a);
    step(1, 3'd1, 16'h0022, 4'd2, 0, a);
    step(1, 3'd1, 16'h0033, 4'd3, 0, a);
    step(1, 3'd1, 16'h0033, 4'd3, 0, a);
    for (int i = 0; i < 8; i++) begin
      step(1, 3'd1, 16'h0033, 4'd3, 1, a);
      if (a) break;
    end
    for (int i = 0; i < 3; i++) step(0, 3'd0, 16'h0, 4'd0, 1, a);

    // Full-rate streaming.
    for (int i = 0; i < 20; i++)
      step(1, 3'($urandom_range(0, 4)), 16'($urandom), 4'(i), 1, a);
    step(0, 3'd0, 16'h0, 4'd0, 1, a);

    // Illegal opcode followed by a legal one.
    step(1, 3'd7, 16'hABCD, 4'd5, 1, a);
    step(1, 3'd2, 16'h1234, 4'd6, 1, a);
    step(0, 3'd0, 16'h0, 4'd0, 1, a);
    step(0, 3'd0, 16'h0, 4'd0, 1, a);

    // Reset with two buffered entries, then recovery.
    step(1, 3'd2, 16'hF00F, 4'd7, 0, a);
    step(1, 3'd3, 16'h5A5A, 4'd8, 0, a);
    reset_mid();
    step(1, 3'd2, 16'h8001, 4'd9, 1, a);
    step(0, 3'd0, 16'h0, 4'd0, 1, a);

    // Random traffic including illegal opcodes and backpressure.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           4'($urandom), ($urandom_range(0, 3) != 0), a);
    for (int i = 0; i < 4; i++) step(0, 3'd0, 16'h0, 4'd0, 1, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, registered immediate-extension unit with valid/ready handshakes on both sides.
- Takes an IN_W-bit instruction immediate plus an extension opcode and a tag.
- Produces the OUT_W-bit extended operand one cycle later, through a 2-entry output buffer.
- Sits between decode and the execute operand mux in the pipelined datapath; replaces the combinational extender of the single-cycle core.
- Adds modes the old extender lacked: upper-placement (LUI) and word-scaled branch offset.

Parameters:
IN_W, 16, immediate width
OUT_W, 32, output width; must satisfy OUT_W >= IN_W+2
SH_LO, 6, LSB of the shift-amount field inside the immediate
SH_W, 5, shift-amount field width; must satisfy SH_LO+SH_W <= IN_W
TAG_W, 4, width of the sideband tag carried alongside the data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
in_imm  in  IN_W  raw immediate
in_op  in  3  extension opcode
in_tag  in  TAG_W  sideband tag, passed through unchanged
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts the beat
out_data  out  OUT_W  extended operand
out_tag  out  TAG_W  tag of the output beat
out_err  out  1  beat carried an illegal opcode

Behaviour:
- Opcodes:
  - 000 SHAMT: zero-extend in_imm[SH_LO+SH_W-1:SH_LO].
  - 001 ZERO: zero-extend in_imm.
  - 010 SIGN: sign-extend in_imm.
  - 011 UPPER: in_imm placed at [OUT_W-1:OUT_W-IN_W], lower bits zero.
  - 100 BRANCH: sign-extend in_imm, then shift left 2; bits beyond OUT_W are dropped.
  - 101/110/111 illegal: out_data=0, out_err=1; the beat is still transferred and ordered normally.
- Handshakes:
  - Input handshake = in_valid && in_ready.
  - Output handshake = out_valid && out_ready.
- Buffer: 2-entry FIFO; occupancy state EMPTY(0) / ONE(1) / FULL(2).
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop in the same cycle -> stays ONE.
  - FULL: pop -> ONE; no push is possible.
- in_ready = (state != FULL). It is driven from registers only and has no combinational path from out_ready. It is forced to 0 while rst_n is low.
- Latency: a beat accepted at edge N is presented at out_* after edge N.
- Throughput: 1 beat/cycle while out_ready stays high.
- Output order is strictly FIFO.
- out_valid = (state != EMPTY). out_data, out_tag and out_err always reflect the head entry.
- While out_valid && !out_ready, out_data, out_tag and out_err are held stable.
- The extension is computed on the input side and stored already extended; the output path has no logic after the storage registers.
- Reset, including mid-operation: all entries are dropped at once. out_valid=0, out_data=0, out_tag=0, out_err=0, state=EMPTY. in_ready=1 from the first clock edge after rst_n rises.
- in_imm, in_op and in_tag are ignored when in_valid=0.

Optional Feature:
IMM_EXT_PERF_EN
- Defined: adds ports xfer_cnt (out, 32) and stall_cnt (out, 32).
  - xfer_cnt increments on each output handshake.
  - stall_cnt increments on each cycle with out_valid && !out_ready.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package imm_ext_pkg: opcode localparams (OP_SHAMT, OP_ZERO, OP_SIGN, OP_UPPER, OP_BRANCH) and the 3-bit opcode width constant.
- Sub-module imm_ext_core: purely combinational opcode -> {data, err} function, parametrised by IN_W, OUT_W, SH_LO and SH_W. It is instantiated once on the input side.
- The FIFO and handshake logic stay in imm_ext_pipe.

Test Plan:
- SIGN, imm 16'h8001, out_ready=1 -> next cycle out_data=32'hFFFF8001, out_err=0; ZERO with the same imm -> 32'h00008001.
- SHAMT imm 16'h07C0 -> 32'h0000001F; UPPER imm 16'h1234 -> 32'h12340000; BRANCH imm 16'hFFFF -> 32'hFFFFFFFC; BRANCH imm 16'h0004 -> 32'h00000010.
- out_ready=0; push tags 1, 2, 3 on consecutive cycles -> in_ready=0 after the 2nd accept and tag 3 is held at the input. Raise out_ready -> outputs in order 1, 2, 3 with no loss or duplication, and data stable while stalled.
- Continuous in_valid=1, out_ready=1 for 20 beats -> 20 outputs on 20 consecutive cycles; state never reaches FULL.
- Illegal op 3'b111, imm 16'hABCD, tag 5 -> out_data=0, out_err=1, out_tag=5; the following legal beat has out_err=0.
- With 2 entries buffered, pulse rst_n low mid-cycle -> out_valid=0 and out_data=0 immediately with no clock edge needed; after release the first new beat comes out correctly. With IMM_EXT_PERF_EN, both counters read 0 after reset.
